ptx_lane_scheduler: RTL and testbench

Schedules the four parallel byte lanes (`data_0p`..`data_3p`) onto the single shared byte slot that feeds the parallel-to-serial transmitter. It runs one byte slot per `clk_4f` cycle gated by `ser_ready`, and grants one lane per slot by round-robin. When no lane has data it inserts K-characters: COM during link synchronization and IDLE otherwise. It also generates `IDLE_OUT` for the receiver side, sitting between the lane FIFOs and the serializer.

---
 rtl/ptx_lane_scheduler.sv | 110 +++++++++++
 tb/tb_ptx_lane_scheduler.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ptx_lane_scheduler.sv
// ptx_lane_scheduler: picks one of four byte lanes per serializer slot, filling empty slots with K-chars
//   clk_4f, reset (async, active-low)      : byte-slot clock and reset
//   data_0p..data_3p, valid_0p..valid_3p   : lane bytes and their availability
//   ser_ready                              : a slot is consumed at this edge
//   ready_0p..ready_3p                     : combinational pop of the winning lane
//   byte_out, byte_valid, is_k, lane_id    : registered slot byte and its qualifiers
//   IDLE_OUT                               : link is idle (registered)
// Build option: define PTX_SCHED_FIXED_PRIO_EN for fixed priority (lane 0 highest) instead of round-robin.
module ptx_lane_scheduler #(
  parameter int SYNC_COUNT  = 4,
  parameter int IDLE_THRESH = 4
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic [7:0] data_0p,
  input  logic [7:0] data_1p,
  input  logic [7:0] data_2p,
  input  logic [7:0] data_3p,
  input  logic       valid_0p,
  input  logic       valid_1p,
  input  logic       valid_2p,
  input  logic       valid_3p,
  input  logic       ser_ready,
  output logic       ready_0p,
  output logic       ready_1p,
  output logic       ready_2p,
  output logic       ready_3p,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       is_k,
  output logic [1:0] lane_id,
  output logic       IDLE_OUT
);
  typedef enum logic [1:0] {SYNC, ACTIVE, IDLE} state_t;
  state_t state, state_d;
  logic [3:0] sync_cnt, sync_d, idle_cnt, idle_d, vld, rdy;
  logic [1:0] ptr, ptr_d, win, lid_d;
  logic [7:0] byte_d;
  logic [7:0] lane_data [4];
  logic hit, bv_d, k_d;
  assign vld = {valid_3p, valid_2p, valid_1p, valid_0p};
  assign lane_data = '{data_0p, data_1p, data_2p, data_3p};
  // Scan from the farthest candidate back to ptr so the lane nearest ptr wins.
  always_comb begin
    hit = |vld;
    win = ptr;
    for (int i = 3; i >= 0; i--)
      if (vld[ptr + 2'(i)]) win = ptr + 2'(i);
  end
  assign rdy = (ser_ready && state != SYNC && hit) ? 4'b0001 << win : 4'b0000;
  assign {ready_3p, ready_2p, ready_1p, ready_0p} = rdy;
  always_comb begin
    state_d = state;
    sync_d  = sync_cnt;
    idle_d  = idle_cnt;
    ptr_d   = ptr;
    byte_d  = byte_out;
    bv_d    = byte_valid;
    k_d     = is_k;
    lid_d   = lane_id;
    if (state == SYNC) begin
      byte_d  = 8'hBC;
      k_d     = 1'b1;
      bv_d    = 1'b0;
      sync_d  = sync_cnt + 4'd1;
      state_d = (sync_d == 4'(SYNC_COUNT)) ? ACTIVE : SYNC;
    end else if (hit) begin
      byte_d  = lane_data[win];
      bv_d    = 1'b1;
      k_d     = 1'b0;
      lid_d   = win;
`ifdef PTX_SCHED_FIXED_PRIO_EN
      ptr_d   = 2'd0;
`else
      ptr_d   = win + 2'd1;
`endif
      idle_d  = 4'd0;
      state_d = ACTIVE;
    end else begin
      byte_d  = 8'h7C;
      k_d     = 1'b1;
      bv_d    = 1'b0;
      idle_d  = (idle_cnt == 4'(IDLE_THRESH)) ? idle_cnt : idle_cnt + 4'd1;
      state_d = (idle_d == 4'(IDLE_THRESH)) ? IDLE : state;
    end
  end
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state      <= SYNC;
      sync_cnt   <= 4'd0;
      idle_cnt   <= 4'd0;
      ptr        <= 2'd0;
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      is_k       <= 1'b0;
      lane_id    <= 2'd0;
      IDLE_OUT   <= 1'b0;
    end else if (ser_ready) begin
      state      <= state_d;
      sync_cnt   <= sync_d;
      idle_cnt   <= idle_d;
      ptr        <= ptr_d;
      byte_out   <= byte_d;
      byte_valid <= bv_d;
      is_k       <= k_d;
      lane_id    <= lid_d;
      IDLE_OUT   <= (state_d == IDLE);
    end
  end
endmodule

// File: tb/tb_ptx_lane_scheduler.sv
// tb_ptx_lane_scheduler: directed table, corner sequences and randomized model check of ptx_lane_scheduler
module tb_ptx_lane_scheduler;
  localparam int SC = 4;
  localparam int TH = 4;
`ifdef PTX_SCHED_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  typedef struct {
    logic [3:0] vld;
    logic       sr;
    logic [7:0] bo;
    logic       bv;
    logic       k;
    logic [1:0] lid;
    logic       io;
    logic [3:0] rdy;
  } vec_t;
  logic clk_4f = 1'b0;
  logic reset = 1'b0;
  logic ser_ready = 1'b0;
  logic [3:0] vld = 4'h0;
  logic [7:0] d [4];
  logic ready_0p, ready_1p, ready_2p, ready_3p, byte_valid, is_k, IDLE_OUT;
  logic [7:0] byte_out;
  logic [1:0] lane_id;
  int tests = 0;
  int fails = 0;
  vec_t tbl[$];
  int m_coms, m_empty, m_nxt;
  bit m_idle;
  logic [7:0] e_bo;
  logic e_bv, e_k;
  logic [1:0] e_lid;

  ptx_lane_scheduler #(.SYNC_COUNT(SC), .IDLE_THRESH(TH)) dut (
    .clk_4f(clk_4f), .reset(reset),
    .data_0p(d[0]), .data_1p(d[1]), .data_2p(d[2]), .data_3p(d[3]),
    .valid_0p(vld[0]), .valid_1p(vld[1]), .valid_2p(vld[2]), .valid_3p(vld[3]),
    .ser_ready(ser_ready),
    .ready_0p(ready_0p), .ready_1p(ready_1p), .ready_2p(ready_2p), .ready_3p(ready_3p),
    .byte_out(byte_out), .byte_valid(byte_valid), .is_k(is_k), .lane_id(lane_id),
    .IDLE_OUT(IDLE_OUT)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] rdy();
    return {ready_3p, ready_2p, ready_1p, ready_0p};
  endfunction

  function automatic vec_t mk(logic [3:0] v, logic s, logic [7:0] b, logic bv, logic k,
                              logic [1:0] l, logic io, logic [3:0] r);
    vec_t x;
    x.vld = v; x.sr = s; x.bo = b; x.bv = bv; x.k = k; x.lid = l; x.io = io; x.rdy = r;
    return x;
  endfunction

  task automatic check_out(input string tag, input logic [7:0] b, input logic bv, input logic k,
                           input logic [1:0] l, input logic io);
    chk({tag, " byte_out"}, byte_out, b);
    chk({tag, " byte_valid"}, byte_valid, bv);
    chk({tag, " is_k"}, is_k, k);
    chk({tag, " lane_id"}, lane_id, l);
    chk({tag, " IDLE_OUT"}, IDLE_OUT, io);
  endtask

  // Reference: COMs are sent until SC have gone out; afterwards the first valid lane
  // searching from the lane after the last winner (or lane 0 under fixed priority) is taken.
  function automatic logic [3:0] predict();
    int start;
    if (!ser_ready || m_coms < SC) return 4'h0;
    start = FIXED ? 0 : m_nxt;
    for (int k = 0; k < 4; k++)
      if (vld[(start + k) % 4]) return 4'(1 << ((start + k) % 4));
    return 4'h0;
  endfunction

  task automatic model_reset();
    m_coms = 0; m_empty = 0; m_nxt = 0; m_idle = 0;
    e_bo = 8'h00; e_bv = 0; e_k = 0; e_lid = 0;
  endtask

  task automatic model_edge(input logic [3:0] g);
    if (!ser_ready) return;
    if (m_coms < SC) begin
      m_coms++;
      e_bo = 8'hBC; e_k = 1; e_bv = 0;
    end else if (g != 0) begin
      for (int n = 0; n < 4; n++)
        if (g[n]) begin
          e_bo = d[n]; e_lid = 2'(n); m_nxt = (n + 1) % 4;
        end
      e_bv = 1; e_k = 0; m_empty = 0; m_idle = 0;
    end else begin
      e_bo = 8'h7C; e_k = 1; e_bv = 0;
      m_empty++;
      if (m_empty >= TH) m_idle = 1;
    end
  endtask

  initial begin
    int lane;
    logic [3:0] g;
    logic [3:0] popped;
    for (int n = 0; n < 4; n++) d[n] = 8'hA0 + 8'(n);
    for (int i = 0; i < SC; i++) tbl.push_back(mk(4'h0, 1, 8'hBC, 0, 1, 0, 0, 4'h0));
    for (int i = 1; i <= TH; i++) tbl.push_back(mk(4'h0, 1, 8'h7C, 0, 1, 0, (i == TH), 4'h0));
    for (int i = 0; i < 5; i++) begin
      lane = FIXED ? 0 : i % 4;
      tbl.push_back(mk(4'hF, 1, 8'hA0 + 8'(lane), 1, 0, 2'(lane), 0, 4'(1 << lane)));
    end
    for (int i = 0; i < 3; i++) tbl.push_back(mk(4'hF, 0, 8'hA0, 1, 0, 0, 0, 4'h0));
    lane = FIXED ? 0 : 1;
    tbl.push_back(mk(4'hF, 1, 8'hA0 + 8'(lane), 1, 0, 2'(lane), 0, 4'(1 << lane)));
    for (int i = 1; i <= TH; i++) tbl.push_back(mk(4'h0, 1, 8'h7C, 0, 1, 2'(lane), (i == TH), 4'h0));

    ser_ready = 1; vld = 4'hF;
    #3;
    check_out("reset", 8'h00, 0, 0, 0, 0);
    chk("reset ready", rdy(), 4'h0);
    vld = 4'h0;
    @(negedge clk_4f) reset = 1;

    foreach (tbl[i]) begin
      vld = tbl[i].vld; ser_ready = tbl[i].sr;
      #1 chk($sformatf("tbl%0d ready", i), rdy(), tbl[i].rdy);
      @(posedge clk_4f); #1;
      check_out($sformatf("tbl%0d", i), tbl[i].bo, tbl[i].bv, tbl[i].k, tbl[i].lid, tbl[i].io);
    end

    d[2] = 8'h55; vld = 4'b0100; ser_ready = 1;
    #1 chk("idle exit ready", rdy(), 4'b0100);
    @(posedge clk_4f); #1;
    check_out("idle exit", 8'h55, 1, 0, 2, 0);

    d[2] = 8'hA2; vld = 4'hF;
    #1 chk("pre-reset ready", rdy(), FIXED ? 4'b0001 : 4'b1000);
    reset = 0;
    #1;
    check_out("async reset", 8'h00, 0, 0, 0, 0);
    chk("async reset ready", rdy(), 4'h0);
    @(posedge clk_4f); #1;
    check_out("held reset", 8'h00, 0, 0, 0, 0);
    @(negedge clk_4f) reset = 1;
    for (int i = 0; i < SC; i++) begin
      #1 chk($sformatf("resync%0d ready", i), rdy(), 4'h0);
      @(posedge clk_4f); #1;
      check_out($sformatf("resync%0d", i), 8'hBC, 0, 1, 0, 0);
    end
    #1 chk("first grant ready", rdy(), 4'b0001);
    @(posedge clk_4f); #1;
    check_out("first grant", 8'hA0, 1, 0, 0, 0);

    vld = 4'h0;
    reset = 0;
    model_reset();
    @(negedge clk_4f) reset = 1;
    popped = 4'h0;
    for (int c = 0; c < 3000; c++) begin
      ser_ready = ($urandom_range(0, 3) != 0);
      for (int n = 0; n < 4; n++)
        if (!vld[n] || popped[n]) begin
          vld[n] = ((c % 64) < 44) && ($urandom_range(0, 2) != 0);
          d[n] = 8'($urandom);
        end
      #1;
      g = predict();
      chk("rnd ready", rdy(), g);
      @(posedge clk_4f);
      model_edge(g);
      popped = g;
      #1;
      check_out("rnd", e_bo, e_bv, e_k, e_lid, m_idle);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
